// File: rtl/auth_access_controller.sv
// Access controller fed by the authentication comparator: grants timed unlocks or counts failures into a lockout.
// Optional build macro AUTH_ALARM_LATCH_EN adds ALARM_CLR and makes ALARM latch past the end of lockout.
module auth_access_controller #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              SUBMIT,
  input  logic                              AUT1,
  input  logic                              AUT2,
  input  logic                              AUT3,
`ifdef AUTH_ALARM_LATCH_EN
  input  logic                              ALARM_CLR,
`endif
  output logic                              UNLOCK,
  output logic [1:0]                        USER_ID,
  output logic                              DENIED,
  output logic                              LOCKED,
  output logic                              ALARM,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] FAILS
);

  // state | meaning
  // IDLE  | waiting for SUBMIT, flags captured on acceptance
  // EVAL  | one cycle to decide grant or deny from captured flags
  // GRANT | UNLOCK held with USER_ID for UNLOCK_CYCLES
  // DENY  | one-cycle DENIED pulse, failure counted
  // LOCK  | LOCKED/ALARM held for LOCKOUT_CYCLES

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAILS_MAX   = FW'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_GRANT, S_DENY, S_LOCK} state_t;

  state_t          state, state_next;
  logic [2:0]      flags;
  logic [TW-1:0]   timer;
  logic            unlock_next, denied_next, locked_next, alarm_next;
  logic [1:0]      user_id_next;
  logic [FW-1:0]   fails_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (SUBMIT) state_next = S_EVAL;
      S_EVAL:  state_next = (|flags) ? S_GRANT : S_DENY;
      S_GRANT: if (timer == '0) state_next = S_IDLE;
      S_DENY:  state_next = (FAILS == FAILS_MAX) ? S_LOCK : S_IDLE;
      S_LOCK:  if (timer == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so they align with state entry.
  always_comb begin
    unlock_next  = (state_next == S_GRANT);
    denied_next  = (state_next == S_DENY);
    locked_next  = (state_next == S_LOCK);
    user_id_next = 2'd0;
    if (state_next == S_GRANT) begin
      if (flags[0])      user_id_next = 2'd1;
      else if (flags[1]) user_id_next = 2'd2;
      else if (flags[2]) user_id_next = 2'd3;
    end
    fails_next = FAILS;
    if (state == S_EVAL && state_next == S_GRANT) begin
      fails_next = '0;
    end else if (state == S_EVAL && state_next == S_DENY && FAILS != FAILS_MAX) begin
      fails_next = FAILS + FW'(1);
    end else if (state == S_LOCK && state_next == S_IDLE) begin
      fails_next = '0;
    end
`ifdef AUTH_ALARM_LATCH_EN
    alarm_next = locked_next | (ALARM & ~(ALARM_CLR & (state != S_LOCK)));
`else
    alarm_next = locked_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags   <= '0;
      timer   <= '0;
      UNLOCK  <= 1'b0;
      USER_ID <= 2'd0;
      DENIED  <= 1'b0;
      LOCKED  <= 1'b0;
      ALARM   <= 1'b0;
      FAILS   <= '0;
    end else begin
      if (state == S_IDLE && SUBMIT) flags <= {AUT3, AUT2, AUT1};
      if (state_next != state) begin
        case (state_next)
          S_GRANT: timer <= UNLOCK_LOAD;
          S_LOCK:  timer <= LOCK_LOAD;
          default: timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - TW'(1);
      end
      UNLOCK  <= unlock_next;
      USER_ID <= user_id_next;
      DENIED  <= denied_next;
      LOCKED  <= locked_next;
      ALARM   <= alarm_next;
      FAILS   <= fails_next;
    end
  end

endmodule
